// File: rtl/shift_seq_ctrl_pkg.sv
// Shared encodings and default sizes for the multi-cycle shift sequencer.
// Optional rotate support is enabled with SHIFT_SEQ_ROTATE_EN.
package shift_seq_ctrl_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SHW   = 5;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_seq_ctrl_stage.sv
// One shared logarithmic shift stage: shifts by 2**k when enabled, else passes data.
// Rotate (op 11) is only built when SHIFT_SEQ_ROTATE_EN is defined.
module shift_stage
  import shift_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int KW    = 3
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [1:0]       op_i,
  input  logic [KW-1:0]    k_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] data_o
);

  int unsigned amt;

  always_comb begin
    data_o = data_i;
    amt    = 32'd1 << k_i;
    if (en_i) begin
      case (op_e'(op_i))
        OP_SLL:  data_o = data_i << amt;
        OP_SRL:  data_o = data_i >> amt;
        OP_SRA:  data_o = $signed(data_i) >>> amt;
`ifdef SHIFT_SEQ_ROTATE_EN
        OP_ROR:  data_o = (data_i >> amt) | (data_i << (WIDTH - int'(amt)));
`else
        OP_ROR:  data_o = data_i;
`endif
        default: data_o = data_i;
      endcase
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shifter sequencer: one shared stage applied SHW times, then a result cycle.
// Define SHIFT_SEQ_ROTATE_EN to make op 11 a rotate-right instead of passthrough.
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHW   = DEF_SHW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_rt,
  input  logic [SHW-1:0]   req_shamt,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_rd,
  output logic             busy
);

  localparam int CW = $clog2(SHW + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SHW-1:0]   shamt_q, shamt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] resp_rd_q, resp_rd_d;

  logic [SHW-1:0]   shamt_sh;
  logic [WIDTH-1:0] stage_out;
  logic             accept;

  // Shifting right by the counter exposes the current stage's bit and reads zero past the last stage.
  assign shamt_sh = shamt_q >> cnt_q;

  shift_stage #(
    .WIDTH(WIDTH),
    .KW   (CW)
  ) u_stage (
    .data_i(data_q),
    .op_i  (op_q),
    .k_i   (cnt_q),
    .en_i  (shamt_sh[0]),
    .data_o(stage_out)
  );

  assign req_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && resp_ready);
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign resp_rd    = resp_rd_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    shamt_d   = shamt_q;
    op_d      = op_q;
    resp_rd_d = resp_rd_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          data_d  = req_rt;
          shamt_d = req_shamt;
          op_d    = req_op;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Counter value SHW is the result cycle that loads the output register.
        if (cnt_q == CW'(SHW)) begin
          resp_rd_d = data_q;
          state_d   = ST_DONE;
        end else begin
          data_d = stage_out;
          cnt_d  = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
          if (accept) begin
            data_d  = req_rt;
            shamt_d = req_shamt;
            op_d    = req_op;
            cnt_d   = '0;
            state_d = ST_SHIFT;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      shamt_q   <= '0;
      op_q      <= '0;
      resp_rd_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      shamt_q   <= shamt_d;
      op_q      <= op_d;
      resp_rd_q <= resp_rd_d;
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed and randomized checks of shift_seq_ctrl latency, fills, backpressure and reset.
// Rotate expectations follow SHIFT_SEQ_ROTATE_EN.
module tb_shift_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_rt = '0;
  logic [4:0]  req_shamt = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rd;
  logic        busy;

  int checks = 0;
  int fails  = 0;

  shift_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_rt    (req_rt),
    .req_shamt (req_shamt),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rd   (resp_rd),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] rt,
                                        input logic [4:0] sh);
    case (op)
      2'b00:   model = rt << sh;
      2'b01:   model = rt >> sh;
      2'b10:   model = $signed(rt) >>> sh;
`ifdef SHIFT_SEQ_ROTATE_EN
      default: model = (rt >> sh) | (rt << (6'd32 - {1'b0, sh}));
`else
      default: model = rt;
`endif
    endcase
  endfunction

  // Drives a request while idle and completes the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] rt, input logic [4:0] sh);
    req_valid = 1'b1;
    req_op    = op;
    req_rt    = rt;
    req_shamt = sh;
    check("req_ready_at_issue", {31'd0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!resp_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic [31:0] rt,
                     input logic [4:0] sh, input logic [31:0] exp);
    int lat;
    issue(op, rt, sh);
    wait_valid(lat);
    check({tag, "_latency"}, lat, 32'd6);
    check({tag, "_value"}, resp_rd, exp);
    $display("txn %s op=%0d rt=%h sh=%0d rd=%h lat=%0d", tag, op, rt, sh, resp_rd, lat);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check({tag, "_drop_valid"}, {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    int lat;
    logic [31:0] held;
    logic [1:0]  rop;
    logic [31:0] rrt;
    logic [4:0]  rsh;
    logic [31:0] rexp;

    #12;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_resp_rd", resp_rd, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    run("sll31", 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000);
    run("sra4", 2'b10, 32'h8000_00F0, 5'd4, 32'hF800_000F);
    run("srl4", 2'b01, 32'h8000_00F0, 5'd4, 32'h0800_000F);
    run("sll0", 2'b00, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF);
    run("srl0", 2'b01, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF);
    run("sra0", 2'b10, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF);
    run("op3_0", 2'b11, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF);
`ifdef SHIFT_SEQ_ROTATE_EN
    run("ror4", 2'b11, 32'hDEAD_BEEF, 5'd4, 32'hFDEA_DBEE);
`else
    run("op3_4", 2'b11, 32'hDEAD_BEEF, 5'd4, 32'hDEAD_BEEF);
`endif

    // Backpressure with a queued request; req_* wiggles while busy must be ignored.
    issue(2'b00, 32'hDEAD_BEEF, 5'd4);
    check("bp_busy", {31'd0, busy}, 32'd1);
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_rt    = 32'hFFFF_FFFF;
    req_shamt = 5'd1;
    check("bp_ready_while_shift", {31'd0, req_ready}, 32'd0);
    req_op    = 2'b00;
    req_rt    = 32'h1234_5678;
    req_shamt = 5'd8;
    wait_valid(lat);
    check("bp_latency", lat, 32'd6);
    held = resp_rd;
    check("bp_value", held, 32'hEADB_EEF0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_valid", {31'd0, resp_valid}, 32'd1);
      check("bp_hold_rd", resp_rd, held);
      check("bp_hold_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    #1;
    check("b2b_ready_comb", {31'd0, req_ready}, 32'd1);
    step();
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    check("b2b_valid_drop", {31'd0, resp_valid}, 32'd0);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_valid(lat);
    check("b2b_latency", lat, 32'd6);
    check("b2b_value", resp_rd, 32'h3456_7800);
    $display("txn b2b rd=%h lat=%0d", resp_rd, lat);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;

    // Asynchronous reset in the middle of stage 2.
    issue(2'b00, 32'h0000_00FF, 5'd7);
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", {31'd0, resp_valid}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_ready", {31'd0, req_ready}, 32'd1);
    check("arst_rd", resp_rd, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check("arst_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    check("arst_ready_after", {31'd0, req_ready}, 32'd1);
    run("post_rst", 2'b01, 32'hF000_000F, 5'd3, 32'h1E00_0001);

    // Random stream with random consumer stall.
    for (int t = 0; t < 40; t++) begin
      rop  = 2'($urandom_range(0, 3));
      rrt  = $urandom;
      rsh  = 5'($urandom_range(0, 31));
      rexp = model(rop, rrt, rsh);
      issue(rop, rrt, rsh);
      wait_valid(lat);
      check("rnd_latency", lat, 32'd6);
      for (int s = $urandom_range(0, 3); s > 0; s--) begin
        step();
        check("rnd_stall_valid", {31'd0, resp_valid}, 32'd1);
      end
      check("rnd_value", resp_rd, rexp);
      $display("txn rnd%0d op=%0d rt=%h sh=%0d rd=%h exp=%h", t, rop, rrt, rsh, resp_rd, rexp);
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      check("rnd_no_dup", {31'd0, resp_valid}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
